// File: rtl/ws2811_pkg.sv
// ws2811_pkg: shared command codes, sequencer states and colour word layout
package ws2811_pkg;
  typedef enum logic [2:0] {
    CMD_PAUSE, CMD_DIR, CMD_PAT_NEXT, CMD_PAT_PREV,
    CMD_SWAP_NEXT, CMD_SWAP_PREV, CMD_BRIGHT_UP, CMD_BRIGHT_DOWN
  } cmd_e;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_WAIT} state_e;
  localparam int SWAP_COUNT = 6;
  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } rgb_t;
endpackage

// File: rtl/ColorScaler.sv
// ColorScaler: combinational channel permutation followed by brightness scaling
module ColorScaler import ws2811_pkg::*; #(
  parameter int BRIGHTNESS_BITS = 3
) (
  input  rgb_t                       color,
  input  logic [2:0]                 swapSel,
  input  logic [BRIGHTNESS_BITS-1:0] level,
  output rgb_t                       scaled
);
  localparam int P = 9 + BRIGHTNESS_BITS;
  logic [P-1:0] gain;
  logic [23:0] swapped, sc;
  assign gain = P'(level) + P'(1);
  assign swapped = swapSel == 3'd1 ? {color.g, color.b, color.r} :
                   swapSel == 3'd2 ? {color.r, color.g, color.b} :
                   swapSel == 3'd3 ? {color.r, color.b, color.g} :
                   swapSel == 3'd4 ? {color.b, color.g, color.r} :
                   swapSel == 3'd5 ? {color.b, color.r, color.g} : color;
  for (genvar i = 0; i < 3; i++) begin : g_ch
    assign sc[8*i +: 8] = 8'((P'(swapped[8*i +: 8]) * gain) >> BRIGHTNESS_BITS);
  end
  assign scaled = sc;
endmodule

// File: rtl/ws2811_frame_sequencer.sv
// ws2811_frame_sequencer: per-frame pattern walker feeding scaled colour words to the transmitter
module ws2811_frame_sequencer import ws2811_pkg::*; #(
  parameter int CLOCK_SPEED           = 50_000_000,
  parameter int UPDATES_PER_SECOND    = 20,
  parameter int UNITS_NUMBER          = 100,
  parameter int PATTERN_COLORS_NUMBER = 128,
  parameter int PATTERNS_NUMBER       = 4,
  parameter int ROM_LATENCY           = 1,
  parameter int BRIGHTNESS_BITS       = 3
) (
  input  logic                                                      clkIN,
  input  logic                                                      nResetIN,
  input  logic                                                      cmdValidIN,
  input  logic [2:0]                                                cmdIN,
  output logic [$clog2(PATTERNS_NUMBER*PATTERN_COLORS_NUMBER)-1:0]  romAddressOUT,
  input  logic [23:0]                                               romDataIN,
  output logic                                                      txStartOUT,
  output logic [23:0]                                               txDataOUT,
  input  logic                                                      txBusyIN,
  output logic                                                      frameActiveOUT,
  output logic                                                      frameOverrunOUT,
  output logic                                                      pauseOUT,
  output logic                                                      directionOUT
);
  localparam int TICK = CLOCK_SPEED / UPDATES_PER_SECOND;
  localparam int TW = $clog2(TICK + 1);
  localparam int CW = $clog2(PATTERN_COLORS_NUMBER);
  localparam int PW = $clog2(PATTERNS_NUMBER);
  localparam int UW = $clog2(UNITS_NUMBER + 1);
  localparam int LW = $clog2(ROM_LATENCY + 1);
  localparam logic [BRIGHTNESS_BITS-1:0] BMAX = '1;
  state_e state;
  logic [TW-1:0] tickCnt;
  logic tick;
  logic [PW-1:0] pattern, patSnap;
  logic [2:0] swapIdx, swapSnap;
  logic [BRIGHTNESS_BITS-1:0] brightness, brightSnap;
  logic [CW-1:0] shift, shiftNext, colorIdx;
  logic [UW-1:0] unitCnt;
  logic [LW-1:0] latCnt;
  rgb_t scaled;
  assign tick = tickCnt == TW'(TICK - 1);
  assign shiftNext = pauseOUT ? shift : directionOUT ? shift + CW'(1) : shift - CW'(1);
  assign romAddressOUT = {patSnap, colorIdx + shift};
  ColorScaler #(.BRIGHTNESS_BITS(BRIGHTNESS_BITS)) scaler (
    .color(romDataIN), .swapSel(swapSnap), .level(brightSnap), .scaled(scaled)
  );
  // free-running frame-rate counter, tick on terminal count
  always_ff @(posedge clkIN or negedge nResetIN)
    if (!nResetIN) tickCnt <= '0;
    else tickCnt <= tick ? '0 : tickCnt + TW'(1);
  // live settings driven by decoded commands
  always_ff @(posedge clkIN or negedge nResetIN)
    if (!nResetIN) begin
      pauseOUT <= 1'b0;
      directionOUT <= 1'b0;
      pattern <= '0;
      swapIdx <= '0;
      brightness <= BMAX;
    end else if (cmdValidIN)
      case (cmd_e'(cmdIN))
        CMD_PAUSE:       pauseOUT <= ~pauseOUT;
        CMD_DIR:         directionOUT <= ~directionOUT;
        CMD_PAT_NEXT:    pattern <= pattern + PW'(1);
        CMD_PAT_PREV:    pattern <= pattern - PW'(1);
        CMD_SWAP_NEXT:   swapIdx <= swapIdx == 3'(SWAP_COUNT - 1) ? 3'd0 : swapIdx + 3'd1;
        CMD_SWAP_PREV:   swapIdx <= swapIdx == 3'd0 ? 3'(SWAP_COUNT - 1) : swapIdx - 3'd1;
        CMD_BRIGHT_UP:   brightness <= brightness == BMAX ? brightness : brightness + BRIGHTNESS_BITS'(1);
        CMD_BRIGHT_DOWN: brightness <= brightness == '0 ? brightness : brightness - BRIGHTNESS_BITS'(1);
      endcase
  // frame FSM: snapshot on tick, then fetch/send/wait once per unit
  always_ff @(posedge clkIN or negedge nResetIN)
    if (!nResetIN) begin
      state <= S_IDLE;
      patSnap <= '0;
      swapSnap <= '0;
      brightSnap <= '0;
      shift <= '0;
      colorIdx <= '0;
      unitCnt <= '0;
      latCnt <= '0;
      txStartOUT <= 1'b0;
      txDataOUT <= '0;
      frameActiveOUT <= 1'b0;
      frameOverrunOUT <= 1'b0;
    end else begin
      txStartOUT <= 1'b0;
      frameOverrunOUT <= tick && state != S_IDLE;
      case (state)
        S_IDLE: if (tick) begin
          state <= S_FETCH;
          patSnap <= pattern;
          swapSnap <= swapIdx;
          brightSnap <= brightness;
          shift <= shiftNext;
          colorIdx <= '0;
          unitCnt <= '0;
          latCnt <= '0;
          frameActiveOUT <= 1'b1;
        end
        S_FETCH:
          if (latCnt == LW'(ROM_LATENCY - 1)) state <= S_SEND;
          else latCnt <= latCnt + LW'(1);
        S_SEND: begin
          txStartOUT <= 1'b1;
          txDataOUT <= scaled;
          state <= S_WAIT;
        end
        S_WAIT: if (!txStartOUT && !txBusyIN) begin
          unitCnt <= unitCnt + UW'(1);
          colorIdx <= colorIdx + CW'(1);
          latCnt <= '0;
          state <= unitCnt == UW'(UNITS_NUMBER - 1) ? S_IDLE : S_FETCH;
          frameActiveOUT <= unitCnt != UW'(UNITS_NUMBER - 1);
        end
      endcase
    end
endmodule
